axi4_lite_rd_arbiter: RTL and testbench



---
 rtl/axi4_lite_rd_arbiter.sv | 174 +++++++++++++++++
 tb/tb_axi4_lite_rd_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_rd_arbiter
// Brief    : Two-master to one-slave AXI4-Lite read-channel arbiter. Master 0
//            is the instruction fetch unit and master 1 is the load/store
//            unit. The grant is locked from AR acceptance until the R
//            handshake, so only one read is ever outstanding.
//            Build option: define ARB_ROUND_ROBIN_EN for round-robin tie
//            resolution. Without it, M1 (LSU) wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2
) (
    input  logic                  iClock,
    input  logic                  iReset,
    // Master 0 (IFU)
    input  logic                  pM0AXI4_ar_valid,
    input  logic [ADDR_WIDTH-1:0] pM0AXI4_ar_bits_addr,
    output logic                  pM0AXI4_ar_ready,
    input  logic                  pM0AXI4_r_ready,
    output logic                  pM0AXI4_r_valid,
    output logic [DATA_WIDTH-1:0] pM0AXI4_r_bits_data,
    output logic [RESP_WIDTH-1:0] pM0AXI4_r_bits_resp,
    // Master 1 (LSU)
    input  logic                  pM1AXI4_ar_valid,
    input  logic [ADDR_WIDTH-1:0] pM1AXI4_ar_bits_addr,
    output logic                  pM1AXI4_ar_ready,
    input  logic                  pM1AXI4_r_ready,
    output logic                  pM1AXI4_r_valid,
    output logic [DATA_WIDTH-1:0] pM1AXI4_r_bits_data,
    output logic [RESP_WIDTH-1:0] pM1AXI4_r_bits_resp,
    // Slave
    output logic                  pSAXI4_ar_valid,
    output logic [ADDR_WIDTH-1:0] pSAXI4_ar_bits_addr,
    input  logic                  pSAXI4_ar_ready,
    output logic                  pSAXI4_r_ready,
    input  logic                  pSAXI4_r_valid,
    input  logic [DATA_WIDTH-1:0] pSAXI4_r_bits_data,
    input  logic [RESP_WIDTH-1:0] pSAXI4_r_bits_resp,
    // Registered one-hot grant: bit0 = M0, bit1 = M1
    output logic [1:0]            oGrant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [1:0] C_GRANT_NONE = 2'b00;
    localparam logic [1:0] C_GRANT_M0   = 2'b01;
    localparam logic [1:0] C_GRANT_M1   = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic       w_pick_m1;
    logic       w_ar_hs;
    logic       w_r_hs;

    assign w_ar_hs = pSAXI4_ar_valid & pSAXI4_ar_ready;
    assign w_r_hs  = pSAXI4_r_valid  & pSAXI4_r_ready;
    assign oGrant  = r_grant;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-granted pointer; reset to "M1" so that M0 wins the first tie.
    logic r_last_m1;

    // Tie goes to whichever master was not granted last.
    always_comb begin
        if (pM0AXI4_ar_valid && pM1AXI4_ar_valid) begin
            w_pick_m1 = ~r_last_m1;
        end else begin
            w_pick_m1 = pM1AXI4_ar_valid;
        end
    end

    // Remember the winner on every IDLE to ADDR transition.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_last_m1 <= 1'b1;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_ADDR)) begin
            r_last_m1 <= w_pick_m1;
        end
    end
`else
    // Fixed priority: the LSU wins whenever it is requesting.
    assign w_pick_m1 = pM1AXI4_ar_valid;
`endif

    // State and grant registers, cleared asynchronously so a reset aborts
    // any transaction in flight.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_grant <= C_GRANT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next state and grant: arbitrate in IDLE, hold the grant until R completes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                if (pM0AXI4_ar_valid || pM1AXI4_ar_valid) begin
                    w_state_nxt = S_ADDR;
                    w_grant_nxt = w_pick_m1 ? C_GRANT_M1 : C_GRANT_M0;
                end
            end
            S_ADDR: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_r_hs) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = C_GRANT_NONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = C_GRANT_NONE;
            end
        endcase
    end

    // Channel muxes steered by the registered grant; everything not owned
    // by the granted master in the current phase is driven to zero.
    always_comb begin
        pSAXI4_ar_valid      = 1'b0;
        pSAXI4_ar_bits_addr  = '0;
        pSAXI4_r_ready       = 1'b0;
        pM0AXI4_ar_ready     = 1'b0;
        pM0AXI4_r_valid      = 1'b0;
        pM0AXI4_r_bits_data  = '0;
        pM0AXI4_r_bits_resp  = '0;
        pM1AXI4_ar_ready     = 1'b0;
        pM1AXI4_r_valid      = 1'b0;
        pM1AXI4_r_bits_data  = '0;
        pM1AXI4_r_bits_resp  = '0;
        if (r_state == S_ADDR) begin
            if (r_grant == C_GRANT_M0) begin
                pSAXI4_ar_valid     = pM0AXI4_ar_valid;
                pSAXI4_ar_bits_addr = pM0AXI4_ar_bits_addr;
                pM0AXI4_ar_ready    = pSAXI4_ar_ready;
            end else if (r_grant == C_GRANT_M1) begin
                pSAXI4_ar_valid     = pM1AXI4_ar_valid;
                pSAXI4_ar_bits_addr = pM1AXI4_ar_bits_addr;
                pM1AXI4_ar_ready    = pSAXI4_ar_ready;
            end
        end else if (r_state == S_DATA) begin
            if (r_grant == C_GRANT_M0) begin
                pM0AXI4_r_valid     = pSAXI4_r_valid;
                pM0AXI4_r_bits_data = pSAXI4_r_bits_data;
                pM0AXI4_r_bits_resp = pSAXI4_r_bits_resp;
                pSAXI4_r_ready      = pM0AXI4_r_ready;
            end else if (r_grant == C_GRANT_M1) begin
                pM1AXI4_r_valid     = pSAXI4_r_valid;
                pM1AXI4_r_bits_data = pSAXI4_r_bits_data;
                pM1AXI4_r_bits_resp = pSAXI4_r_bits_resp;
                pSAXI4_r_ready      = pM1AXI4_r_ready;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_rd_arbiter
// Brief    : Directed self-checking bench for axi4_lite_rd_arbiter. The slave
//            side is driven directly by the stimulus sequence. Tie
//            expectations follow ARB_ROUND_ROBIN_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_rd_arbiter;

    localparam logic [31:0] C_A0 = 32'h0000_1000;
    localparam logic [31:0] C_A1 = 32'h2000_0040;

    logic        iClock;
    logic        iReset;
    logic        m0_arv, m0_arr, m0_rr, m0_rv;
    logic [31:0] m0_addr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arv, m1_arr, m1_rr, m1_rv;
    logic [31:0] m1_addr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        s_arv, s_arr, s_rr, s_rv;
    logic [31:0] s_addr, s_rdata;
    logic [1:0]  s_rresp;
    logic [1:0]  oGrant;

    int tests = 0;
    int fails = 0;
    logic [3:0] tie_exp_m1;

    axi4_lite_rd_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESP_WIDTH(2)
    ) u_dut (
        .iClock               (iClock),
        .iReset               (iReset),
        .pM0AXI4_ar_valid     (m0_arv),
        .pM0AXI4_ar_bits_addr (m0_addr),
        .pM0AXI4_ar_ready     (m0_arr),
        .pM0AXI4_r_ready      (m0_rr),
        .pM0AXI4_r_valid      (m0_rv),
        .pM0AXI4_r_bits_data  (m0_rdata),
        .pM0AXI4_r_bits_resp  (m0_rresp),
        .pM1AXI4_ar_valid     (m1_arv),
        .pM1AXI4_ar_bits_addr (m1_addr),
        .pM1AXI4_ar_ready     (m1_arr),
        .pM1AXI4_r_ready      (m1_rr),
        .pM1AXI4_r_valid      (m1_rv),
        .pM1AXI4_r_bits_data  (m1_rdata),
        .pM1AXI4_r_bits_resp  (m1_rresp),
        .pSAXI4_ar_valid      (s_arv),
        .pSAXI4_ar_bits_addr  (s_addr),
        .pSAXI4_ar_ready      (s_arr),
        .pSAXI4_r_ready       (s_rr),
        .pSAXI4_r_valid       (s_rv),
        .pSAXI4_r_bits_data   (s_rdata),
        .pSAXI4_r_bits_resp   (s_rresp),
        .oGrant               (oGrant)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // One comparison: count it, and on mismatch count and report it.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        m0_arv = 0; m1_arv = 0; s_rv = 0; s_rresp = 0; s_rdata = 0;
        repeat (2) tick();
        iReset = 1'b0;
    endtask

    // Both masters are requesting in IDLE; run one complete read and
    // re-raise the winner's request so the next round is a tie again.
    task automatic tie_round(input int n, input logic exp_m1);
        tick();
        #1;
        chk($sformatf("tie%0d_grant", n), oGrant, exp_m1 ? 2'b10 : 2'b01);
        chk($sformatf("tie%0d_addr", n), s_addr, exp_m1 ? C_A1 : C_A0);
        chk($sformatf("tie%0d_loser_arr", n), exp_m1 ? m0_arr : m1_arr, 1'b0);
        tick();
        if (exp_m1) m1_arv = 0; else m0_arv = 0;
        s_rv = 1; s_rdata = 32'h1000_0000 + n; s_rresp = 0;
        #1;
        chk($sformatf("tie%0d_rdata", n), exp_m1 ? m1_rdata : m0_rdata, 32'h1000_0000 + n);
        chk($sformatf("tie%0d_loser_rv", n), exp_m1 ? m0_rv : m1_rv, 1'b0);
        tick();
        s_rv = 0;
        #1;
        chk($sformatf("tie%0d_idle_grant", n), oGrant, 2'b00);
        if (exp_m1) m1_arv = 1; else m0_arv = 1;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp_m1 = 4'b1010;
`else
        tie_exp_m1 = 4'b1111;
`endif
        iReset = 1; m0_arv = 0; m1_arv = 0; m0_addr = 0; m1_addr = 0;
        m0_rr = 0; m1_rr = 0; s_arr = 0; s_rv = 0; s_rdata = 0; s_rresp = 0;
        #2;
        // ---------------- reset state
        chk("rst_grant", oGrant, 2'b00);
        chk("rst_s_arv", s_arv, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        do_reset();

        // ---------------- single read from M0
        m0_arv = 1; m0_addr = 32'h8000_0000; s_arr = 1;
        #1;
        chk("sr_idle_grant", oGrant, 2'b00);
        chk("sr_idle_s_arv", s_arv, 1'b0);
        chk("sr_idle_m0_arr", m0_arr, 1'b0);
        tick();
        #1;
        chk("sr_addr_grant", oGrant, 2'b01);
        chk("sr_addr_s_arv", s_arv, 1'b1);
        chk("sr_addr_s_addr", s_addr, 32'h8000_0000);
        chk("sr_addr_m0_arr", m0_arr, 1'b1);
        chk("sr_addr_m1_arr", m1_arr, 1'b0);
        tick();
        m0_arv = 0; s_rv = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00; m0_rr = 1;
        #1;
        chk("sr_data_m0_rv", m0_rv, 1'b1);
        chk("sr_data_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("sr_data_s_rr", s_rr, 1'b1);
        chk("sr_data_s_addr", s_addr, 32'h0);
        chk("sr_data_m1_rv", m1_rv, 1'b0);
        chk("sr_data_m1_rdata", m1_rdata, 32'h0);
        tick();
        s_rv = 0;
        #1;
        chk("sr_end_grant", oGrant, 2'b00);
        chk("sr_end_m0_rv", m0_rv, 1'b0);

        // ---------------- four back-to-back tie rounds
        do_reset();
        m0_addr = C_A0; m1_addr = C_A1; m0_rr = 1; m1_rr = 1; s_arr = 1;
        m0_arv = 1; m1_arv = 1;
        for (int r = 0; r < 4; r++) tie_round(r, tie_exp_m1[r]);
        m0_arv = 0; m1_arv = 0;

        // ---------------- late M1 request while M0 waits 5 cycles in DATA
        m0_arv = 1;
        tick();
        tick();
        m0_arv = 0; m1_arv = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("late_wait%0d_m1_arr", i), m1_arr, 1'b0);
            chk($sformatf("late_wait%0d_grant", i), oGrant, 2'b01);
            tick();
        end
        s_rv = 1; s_rdata = 32'h0BAD_F00D;
        #1;
        chk("late_m0_rv", m0_rv, 1'b1);
        chk("late_m1_arr_data", m1_arr, 1'b0);
        tick();
        s_rv = 0;
        #1;
        chk("late_bubble_grant", oGrant, 2'b00);
        chk("late_bubble_m1_arr", m1_arr, 1'b0);
        tick();
        #1;
        chk("late_m1_grant", oGrant, 2'b10);
        chk("late_m1_arr", m1_arr, 1'b1);
        chk("late_m1_addr", s_addr, C_A1);
        tick();
        m1_arv = 0; s_rv = 1; s_rdata = 32'h1234_5678;
        #1;
        chk("late_m1_rdata", m1_rdata, 32'h1234_5678);
        tick();
        s_rv = 0;

        // ---------------- backpressure on AR (3 cycles) and R (2 cycles)
        s_arr = 0; m0_rr = 0; m0_arv = 1; m0_addr = 32'h0000_0ABC;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ar%0d_grant", i), oGrant, 2'b01);
            chk($sformatf("bp_ar%0d_s_arv", i), s_arv, 1'b1);
            chk($sformatf("bp_ar%0d_addr", i), s_addr, 32'h0000_0ABC);
            tick();
        end
        s_arr = 1;
        tick();
        m0_arv = 0; s_rv = 1; s_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("bp_r%0d_rv", i), m0_rv, 1'b1);
            chk($sformatf("bp_r%0d_rdata", i), m0_rdata, 32'hCAFE_0001);
            chk($sformatf("bp_r%0d_s_rr", i), s_rr, 1'b0);
            chk($sformatf("bp_r%0d_grant", i), oGrant, 2'b01);
            tick();
        end
        m0_rr = 1;
        #1;
        chk("bp_release_s_rr", s_rr, 1'b1);
        tick();
        s_rv = 0;
        #1;
        chk("bp_done_grant", oGrant, 2'b00);
        tick();
        #1;
        chk("bp_single_xfer_grant", oGrant, 2'b00);

        // ---------------- SLVERR passes through to M1
        m1_arv = 1;
        tick();
        tick();
        m1_arv = 0; s_rv = 1; s_rdata = 32'h0; s_rresp = 2'b10;
        #1;
        chk("err_m1_resp", m1_rresp, 2'b10);
        chk("err_m0_resp", m0_rresp, 2'b00);
        tick();
        s_rv = 0; s_rresp = 0;
        #1;
        chk("err_idle_grant", oGrant, 2'b00);
        tick();
        #1;
        chk("err_stay_idle", oGrant, 2'b00);

        // ---------------- asynchronous reset while in DATA
        m0_arv = 1;
        tick();
        tick();
        m0_arv = 0; s_rv = 1; s_rdata = 32'h5555_AAAA;
        #1;
        chk("rstd_pre_m0_rv", m0_rv, 1'b1);
        #1;
        iReset = 1;
        #1;
        chk("rstd_grant", oGrant, 2'b00);
        chk("rstd_m0_rv", m0_rv, 1'b0);
        chk("rstd_m0_rdata", m0_rdata, 32'h0);
        chk("rstd_s_rr", s_rr, 1'b0);
        s_rv = 0; s_rdata = 0;
        tick();
        iReset = 0; m0_arv = 1; m1_arv = 1;
        tick();
        #1;
        chk("rstd_first_tie", oGrant, tie_exp_m1[0] ? 2'b10 : 2'b01);
        m0_arv = 0; m1_arv = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
